// File: rtl/flash_responder.sv
// flash_responder: chip-side model of a 16-bit CFI NOR flash (Intel command
// subset). Word array with command decoding, status register and timed
// program/erase busy periods.
`timescale 1ns/1ps
module flash_responder #(
  parameter int          ADDR_W       = 10,
  parameter int          BLOCK_W      = 6,
  parameter int          PROG_CYCLES  = 20,   // must be >= 2 (read-modify-write)
  parameter int          ERASE_CYCLES = 200,  // must be >= 2**BLOCK_W
  parameter logic [15:0] DEVICE_ID    = 16'h0018
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [22:0] flash_addr,
  inout  wire  [15:0] flash_data,
  input  logic [7:0]  flash_ctl,
  output logic        busy
);

  localparam int WORDS     = 1 << ADDR_W;
  localparam int BLK_WORDS = 1 << BLOCK_W;
  localparam int MAX_CYC   = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG_SETUP,
    ST_ERASE_SETUP,
    ST_PROG_BUSY,
    ST_ERASE_BUSY
  } state_t;

  typedef enum logic [1:0] {
    MODE_ARRAY,
    MODE_STATUS,
    MODE_ID
  } mode_t;

  // control decode
  logic              w_oe_n;
  logic              w_we_n;
  logic              w_rp_n;
  logic              w_vpen;
  logic              w_sel;
  logic              w_drive;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  assign w_oe_n  = flash_ctl[4];
  assign w_rp_n  = flash_ctl[5];
  assign w_vpen  = flash_ctl[6];
  assign w_we_n  = flash_ctl[7];
  assign w_sel   = ~flash_ctl[1] & w_rp_n;
  assign w_drive = w_sel & ~w_oe_n & w_we_n;
  assign w_addr  = flash_addr[ADDR_W:1];
  // byte_n, ce1, ce2, the byte-lane bit and the upper address bits have no effect
  assign w_unused = ^{flash_addr[22:ADDR_W+1], flash_addr[0], flash_ctl[3:2], flash_ctl[0]};

  // registers
  state_t            r_state;
  mode_t             r_mode;
  logic [2:0]        r_err;        // {erase err (SR5), program err (SR4), vpen err (SR3)}
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_op_addr;
  logic [15:0]       r_op_data;
  logic              r_we_low;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic [15:0]       r_mem [WORDS];
  logic [15:0]       r_old;        // current contents of the word being programmed
  logic [15:0]       r_arr_q;      // array read port for the bus
  logic              r_rd_arr;     // bus shows array data (else r_info_q)
  logic [15:0]       r_info_q;     // status / ID word for the bus

  // next-state / control wires
  state_t            w_state_next;
  mode_t             w_mode_next;
  logic [2:0]        w_err_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_op_load;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [15:0]       w_mem_wdata;
  logic              w_commit;
  logic [7:0]        w_sr;
  logic [15:0]       w_id_word;
  logic [15:0]       w_rdata;

  assign busy     = (r_state == ST_PROG_BUSY) || (r_state == ST_ERASE_BUSY);
  assign w_commit = w_sel & w_we_n & r_we_low;
  assign w_sr     = {~busy, 1'b0, r_err, 3'b000};
  assign w_id_word = (w_addr == '0)                    ? 16'h0089  :
                     (w_addr == ADDR_W'(1))            ? DEVICE_ID : 16'h0000;
  assign w_rdata  = r_rd_arr ? r_arr_q : r_info_q;
  assign flash_data = w_drive ? w_rdata : 16'hzzzz;

  // latch address/data while write strobe is low; a commit needs the strobe to rise while selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_low  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_sel && !w_we_n) begin
      r_we_low  <= 1'b1;
      r_wr_addr <= w_addr;
      r_wr_data <= flash_data;
    end else begin
      r_we_low  <= 1'b0;
    end
  end

  // command decoder, busy sequencing and array write control
  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_err_next   = r_err;
    w_cnt_next   = r_cnt;
    w_op_load    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = r_op_addr;
    w_mem_wdata  = r_old & r_op_data;
    if (!w_rp_n) begin
      w_state_next = ST_IDLE;
      w_mode_next  = MODE_ARRAY;
      w_err_next   = 3'b000;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_commit) begin
            case (r_wr_data[7:0])
              8'hFF: w_mode_next = MODE_ARRAY;
              8'h70: w_mode_next = MODE_STATUS;
              8'h90: w_mode_next = MODE_ID;
              8'h50: w_err_next  = 3'b000;
              8'h40, 8'h10: begin
                w_state_next = ST_PROG_SETUP;
                w_mode_next  = MODE_STATUS;
              end
              8'h20: begin
                w_state_next = ST_ERASE_SETUP;
                w_mode_next  = MODE_STATUS;
              end
              default: ;
            endcase
          end
        end
        ST_PROG_SETUP: begin
          if (w_commit) begin
            if (!w_vpen) begin
              w_err_next   = r_err | 3'b011;
              w_state_next = ST_IDLE;
            end else begin
              w_op_load    = 1'b1;
              w_cnt_next   = '0;
              w_state_next = ST_PROG_BUSY;
            end
          end
        end
        ST_ERASE_SETUP: begin
          if (w_commit) begin
            if (r_wr_data[7:0] != 8'hD0) begin
              w_err_next   = r_err | 3'b110;
              w_state_next = ST_IDLE;
            end else if (!w_vpen) begin
              w_err_next   = r_err | 3'b101;
              w_state_next = ST_IDLE;
            end else begin
              w_op_load    = 1'b1;
              w_cnt_next   = '0;
              w_state_next = ST_ERASE_BUSY;
            end
          end
        end
        ST_PROG_BUSY: begin
          // r_old is fetched during count 0, so the AND-write lands on count 1
          if (r_cnt == CNT_W'(1)) begin
            w_mem_we = 1'b1;
          end
          if (r_cnt == CNT_W'(PROG_CYCLES - 1)) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
          end
        end
        ST_ERASE_BUSY: begin
          if ({1'b0, r_cnt} < (CNT_W + 1)'(BLK_WORDS)) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {r_op_addr[ADDR_W-1:BLOCK_W], r_cnt[BLOCK_W-1:0]};
            w_mem_wdata = 16'hFFFF;
          end
          if (r_cnt == CNT_W'(ERASE_CYCLES - 1)) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // state, mode, error bits, counter and operation operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_ARRAY;
      r_err     <= 3'b000;
      r_cnt     <= '0;
      r_op_addr <= '0;
      r_op_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
      if (w_op_load) begin
        r_op_addr <= r_wr_addr;
        r_op_data <= r_wr_data;
      end
    end
  end

  // word array: one write port, registered reads for the bus and for program read-modify-write
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
    r_old   <= r_mem[r_op_addr];
    r_arr_q <= r_mem[w_addr];
  end

  // read source select and status/ID word; while busy the bus always shows status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_arr <= 1'b0;
      r_info_q <= 16'h0000;
    end else begin
      r_rd_arr <= (r_mode == MODE_ARRAY) && !busy;
      if (busy || r_mode == MODE_STATUS) begin
        r_info_q <= {8'h00, w_sr};
      end else if (r_mode == MODE_ID) begin
        r_info_q <= w_id_word;
      end else begin
        r_info_q <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder: directed stimulus for flash_responder with a cycle-level
// behavioural model compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_flash_responder;

  localparam int          ADDR_W = 10;
  localparam int          PROG   = 20;
  localparam int          ERASE  = 200;
  localparam logic [15:0] DEV_ID = 16'h0018;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] flash_addr = '0;
  tri1  [15:0] flash_data;          // undriven bus reads as all ones
  logic [15:0] tb_wdata = '0;
  logic        ce_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        we_n = 1'b1;
  logic        rp_n = 1'b1;
  logic        vpen = 1'b1;
  logic [7:0]  flash_ctl;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  assign flash_ctl  = {we_n, vpen, rp_n, oe_n, 1'b1, 1'b0, ce_n, 1'b1};
  assign flash_data = we_n ? 16'hzzzz : tb_wdata;

  flash_responder #(
    .ADDR_W(ADDR_W), .BLOCK_W(6), .PROG_CYCLES(PROG), .ERASE_CYCLES(ERASE), .DEVICE_ID(DEV_ID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_ctl(flash_ctl), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem   [0:1023];
  bit          m_known [0:1023];
  int          m_mode = 0;          // 0 array, 1 status, 2 id
  int          m_phase = 0;         // 0 command, 1 program data, 2 erase confirm
  int          m_left = 0;          // busy cycles remaining
  logic [2:0]  m_err = 3'b000;      // {SR5, SR4, SR3}
  bit          m_wlow = 0;
  int          m_waddr = 0;
  logic [15:0] m_wdata = '0;
  bit          m_erasing = 0;
  int          m_ebase = 0;
  logic [15:0] m_rd = '0;           // value the bus shows this cycle when read
  bit          m_rd_ok = 1;

  initial begin : model
    int         wa;
    bit         busy_now;
    logic [7:0] cmd;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_phase = 0; m_left = 0; m_err = 3'b000; m_wlow = 0;
        m_erasing = 0; m_rd = 16'h0000; m_rd_ok = 1;
      end else begin
        wa = int'(flash_addr[ADDR_W:1]);
        busy_now = (m_left > 0);
        if (busy_now || m_mode == 1) begin
          m_rd = {8'h00, !busy_now, 1'b0, m_err, 3'b000}; m_rd_ok = 1;
        end else if (m_mode == 2) begin
          m_rd = (wa == 0) ? 16'h0089 : (wa == 1) ? DEV_ID : 16'h0000; m_rd_ok = 1;
        end else begin
          m_rd = m_mem[wa]; m_rd_ok = m_known[wa];
        end
        if (!rp_n) begin
          if (busy_now && m_erasing)
            for (int i = 0; i < 64; i++) m_known[m_ebase + i] = 0;
          m_mode = 0; m_phase = 0; m_left = 0; m_err = 3'b000; m_wlow = 0; m_erasing = 0;
        end else begin
          if (busy_now) begin
            m_left = m_left - 1;
          end else if (!ce_n && we_n && m_wlow) begin
            cmd = m_wdata[7:0];
            if (m_phase == 1) begin
              m_phase = 0;
              if (!vpen) m_err = m_err | 3'b011;
              else begin
                m_mem[m_waddr] = m_mem[m_waddr] & m_wdata;
                m_left = PROG; m_erasing = 0;
              end
            end else if (m_phase == 2) begin
              m_phase = 0;
              if (cmd != 8'hD0) m_err = m_err | 3'b110;
              else if (!vpen) m_err = m_err | 3'b101;
              else begin
                m_ebase = m_waddr & ~63;
                for (int i = 0; i < 64; i++) begin
                  m_mem[m_ebase + i] = 16'hFFFF; m_known[m_ebase + i] = 1;
                end
                m_left = ERASE; m_erasing = 1;
              end
            end else begin
              case (cmd)
                8'hFF: m_mode = 0;
                8'h70: m_mode = 1;
                8'h90: m_mode = 2;
                8'h50: m_err = 3'b000;
                8'h40, 8'h10: begin m_phase = 1; m_mode = 1; end
                8'h20: begin m_phase = 2; m_mode = 1; end
                default: ;
              endcase
            end
          end
          if (!ce_n && !we_n) begin
            m_wlow = 1; m_waddr = wa; m_wdata = flash_data;
          end else begin
            m_wlow = 0;
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // every-cycle compare of busy and bus against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check16("busy_cycle", {15'h0, busy}, {15'h0, (m_left > 0)});
        if (we_n) begin
          if (!ce_n && rp_n && !oe_n) begin
            if (m_rd_ok) check16("bus_cycle", flash_data, m_rd);
          end else begin
            check16("bus_z_cycle", flash_data, 16'hFFFF);
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic bus_write(input logic [9:0] wa, input logic [15:0] d);
    @(posedge clk); #1;
    flash_addr = {12'h000, wa, 1'b0};
    tb_wdata = d;
    we_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    we_n = 1'b1;
    @(posedge clk); #1;            // commit edge just passed
    $display("WR addr=%h data=%h vpen=%0d", wa, d, vpen);
  endtask

  task automatic rd_check(input string name, input logic [9:0] wa, input logic [15:0] exp);
    @(posedge clk); #1;
    flash_addr = {12'h000, wa, 1'b0};
    oe_n = 1'b0;
    @(posedge clk); #1;            // data valid one clock after the address
    $display("RD %s addr=%h data=%h exp=%h", name, wa, flash_data, exp);
    check16(name, flash_data, exp);
    oe_n = 1'b1;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    busy_len(n);
    check16("idle_reached", {15'h0, busy}, 16'h0000);
  endtask

  task automatic erase_block(input logic [9:0] wa);
    bus_write(wa, 16'h0020);
    bus_write(wa, 16'h00D0);
    wait_idle();
  endtask

  task automatic program_word(input logic [9:0] wa, input logic [15:0] d);
    bus_write(wa, 16'h0040);
    bus_write(wa, d);
    wait_idle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int          n;
    logic [15:0] got_mid;
    repeat (3) @(posedge clk);
    #1;
    check16("rst_busy", {15'h0, busy}, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ce_n = 1'b0;

    bus_write(10'h000, 16'h0070);
    rd_check("sr_after_reset", 10'h000, 16'h0080);

    // known contents for blocks 0..3
    erase_block(10'h000);
    erase_block(10'h040);
    erase_block(10'h080);
    erase_block(10'h0C0);
    program_word(10'h005, 16'h5A5A);
    program_word(10'h03F, 16'h1111);
    program_word(10'h080, 16'h2222);
    program_word(10'h00B, 16'h0F0F);
    program_word(10'h046, 16'h0000);

    // array read, bus Z with oe_n high
    bus_write(10'h000, 16'h00FF);
    @(posedge clk); #1;
    flash_addr = {12'h000, 10'h005, 1'b0};
    @(posedge clk); #1;
    @(posedge clk); #1;
    check16("bus_z_oe_high", flash_data, 16'hFFFF);
    rd_check("array_w5", 10'h005, 16'h5A5A);

    // program 0x1234 into erased word 0x0A
    bus_write(10'h00A, 16'h0040);
    bus_write(10'h00A, 16'h1234);
    oe_n = 1'b0;
    got_mid = 16'hxxxx;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) got_mid = flash_data;
    end
    check_int("prog_busy_len", n, PROG);
    check16("prog_rd_busy", got_mid, 16'h0000);
    @(posedge clk); #1;
    check16("prog_rd_done", flash_data, 16'h0080);
    oe_n = 1'b1;
    bus_write(10'h000, 16'h00FF);
    rd_check("prog_readback", 10'h00A, 16'h1234);

    // program can only clear bits
    program_word(10'h00B, 16'h00F0);
    bus_write(10'h000, 16'h00FF);
    rd_check("prog_and", 10'h00B, 16'h0000);

    // block erase at word 0x45
    bus_write(10'h045, 16'h0020);
    bus_write(10'h045, 16'h00D0);
    busy_len(n);
    check_int("erase_busy_len", n, ERASE);
    bus_write(10'h000, 16'h00FF);
    for (int w = 'h40; w <= 'h7F; w++) rd_check("erase_word", 10'(w), 16'hFFFF);
    rd_check("erase_below", 10'h03F, 16'h1111);
    rd_check("erase_above", 10'h080, 16'h2222);

    // sequence error, no erase, then clear
    bus_write(10'h005, 16'h0020);
    bus_write(10'h005, 16'h0033);
    check16("seqerr_busy", {15'h0, busy}, 16'h0000);
    rd_check("sr_seqerr", 10'h005, 16'h00B0);
    bus_write(10'h000, 16'h0050);
    rd_check("sr_cleared", 10'h005, 16'h0080);

    // program with vpen low
    bus_write(10'h005, 16'h0040);
    vpen = 1'b0;
    bus_write(10'h005, 16'h0000);
    vpen = 1'b1;
    rd_check("sr_vpen_prog", 10'h005, 16'h0098);
    bus_write(10'h000, 16'h0050);

    // erase confirm with vpen low
    bus_write(10'h005, 16'h0020);
    vpen = 1'b0;
    bus_write(10'h005, 16'h00D0);
    vpen = 1'b1;
    rd_check("sr_vpen_erase", 10'h005, 16'h00A8);
    bus_write(10'h000, 16'h0050);
    bus_write(10'h000, 16'h00FF);
    rd_check("array_intact", 10'h005, 16'h5A5A);

    // read ID
    bus_write(10'h000, 16'h0090);
    rd_check("id_mfr", 10'h000, 16'h0089);
    rd_check("id_dev", 10'h001, 16'h0018);
    rd_check("id_other", 10'h002, 16'h0000);
    bus_write(10'h000, 16'h00FF);

    // rp_n abort mid-erase of block 3 (words 0xC0..0xFF hold their own index)
    for (int w = 'hC0; w <= 'hFF; w++) program_word(10'(w), {6'h00, 10'(w)});
    bus_write(10'h0C0, 16'h0020);
    bus_write(10'h0C0, 16'h00D0);
    repeat (10) @(posedge clk);
    #1;
    rp_n = 1'b0;
    oe_n = 1'b0;
    @(posedge clk); #1;
    check16("abort_busy", {15'h0, busy}, 16'h0000);
    check16("abort_bus_z", flash_data, 16'hFFFF);
    oe_n = 1'b1;
    rp_n = 1'b1;
    for (int w = 'hC0; w <= 'hC8; w++) rd_check("abort_erased", 10'(w), 16'hFFFF);
    for (int w = 'hCC; w <= 'hFF; w++) rd_check("abort_kept", 10'(w), {6'h00, 10'(w)});

    // asynchronous reset mid-program
    bus_write(10'h00C, 16'h0040);
    bus_write(10'h00C, 16'h0000);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check16("async_rst_busy", {15'h0, busy}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_write(10'h000, 16'h0070);
    rd_check("sr_after_rst", 10'h000, 16'h0080);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // hard stop in case a wait never resolves
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
